fir_stream_param: RTL and testbench
===================================

Name: fir_stream_param

Overview:
- Parametrised direct-form FIR for the streaming datapath; the next generation of the team's fixed 3-tap FIR.
- Adds run-time coefficient loading with commit/abort, a valid/ready input handshake and an output valid strobe.
- Adds optional symmetric coefficient folding, plus rounding and saturation to the output width.
- Sits between the sample source and downstream consumers; never stalls once a sample is accepted.

Parameters:
- NTAPS, 5, number of taps (>=2).
- X_W, 8, signed input sample width.
- COEF_W, 8, signed coefficient width.
- Y_W, 12, signed output width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.
- SYMM, 0, when 1 only M=ceil(NTAPS/2) coefficients are loaded and mirrored.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  X_W  signed sample.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- coef_load  in  1  high = coefficient load session.
- coef_valid  in  1  coef_data valid this cycle.
- coef_data  in  COEF_W  signed coefficient word.
- coef_done  out  1  one-cycle pulse: full set committed.
- coef_err  out  1  one-cycle pulse: session aborted.
- out_data  out  Y_W  signed filtered result.
- out_valid  out  1  one-cycle pulse per accepted sample.
- out_sat  out  1  out_data was saturated (qualified by out_valid).

Behaviour:
- Reset:
  - state=RUN; delay line x[0..NTAPS-1]=0; shadow registers and word counter=0.
  - Active coefficients: c[NTAPS/2 (integer division)]=1, all others 0, giving a delayed passthrough.
  - out_data=0; out_valid, out_sat, coef_done, coef_err=0.
  - Reset mid-load discards the session with no coef_err pulse.
- States: RUN, LOAD.
  - RUN->LOAD when coef_load=1; LOAD->RUN when coef_load=0.
  - in_ready = (state==RUN) && !coef_load, combinational.
  - When coef_load and in_valid are high together, coef_load wins and the sample is not accepted.
- Sample path:
  - On accept (in_valid && in_ready) at edge E: x[0]<=in_data, x[i]<=x[i-1].
  - At edge E+1: out_data = sat(round(sum c[i]*x[i])) and out_valid=1 for one cycle.
  - Sustains one sample per cycle back-to-back. Any accept preceding entry to LOAD still produces its output.
  - When no sample is accepted, out_valid=0 and out_data holds its last value.
- Arithmetic:
  - Full-precision accumulator of width X_W+COEF_W+clog2(NTAPS), signed.
  - If SHIFT>0: add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
  - Clamp to [-2^(Y_W-1), 2^(Y_W-1)-1]; out_sat=1 iff clamping occurred.
- Coefficient load:
  - Words are counted in LOAD only when coef_valid=1. Word j is written to shadow s[j], j=0..K-1, with K=NTAPS (SYMM=0) or M (SYMM=1).
  - On the K-th word, the shadow is copied to the active set on the same edge and coef_done pulses the next cycle. For SYMM=1, c[j]=c[NTAPS-1-j]=s[j].
  - Words beyond K in the same session are ignored.
  - If coef_load falls with 0<count<K: active coefficients are unchanged and coef_err pulses. With count=0: no pulse.
  - On LOAD->RUN exit, the delay line is cleared to 0 and the counter reset.

Test Plan:
- Impulse passthrough: NTAPS=5, SHIFT=0, post-reset defaults; stream 10,0,0,0,0 back-to-back -> out_valid on 5 consecutive cycles, out_data 0,0,10,0,0.
- Load and commit: load words 1,2,3,4,5 -> coef_done single pulse; in_ready=0 during load; then impulse 1,0,0,0,0 -> out_data 1,2,3,4,5.
- Abort: load 7,7,7 then drop coef_load -> coef_err pulse, no coef_done; impulse 10 -> out_data 0,0,10,0,0 (defaults kept).
- Saturation, Y_W=12: all coefficients 127, five samples of 127 -> last out_data 2047 with out_sat=1. All coefficients 127, five samples of -128 -> -2048, out_sat=1.
- Symmetric/round, SYMM=1, SHIFT=1: load 1,2,3 (coef_done after 3rd word) -> impulse 4 gives out_data 2,4,6,4,2. Impulse 1 gives 1,1,2,1,1 (round half up).
- Conflict/reset: in_valid and coef_load asserted in the same cycle -> no accept, in_ready=0. Reset after 2 load words -> defaults restored, no coef_err, out_valid=0.

Source files
------------

// File: rtl/fir_stream_param.sv
// Parametrised direct-form streaming FIR with run-time coefficient loading (commit/abort),
// optional symmetric folding, round-half-up and saturation to the output width.
module fir_stream_param #(
  parameter int NTAPS  = 5,
  parameter int X_W    = 8,
  parameter int COEF_W = 8,
  parameter int Y_W    = 12,
  parameter int SHIFT  = 0,
  parameter int SYMM   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [X_W-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     coef_load,
  input  logic                     coef_valid,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_done,
  output logic                     coef_err,
  output logic signed [Y_W-1:0]    out_data,
  output logic                     out_valid,
  output logic                     out_sat
);

  localparam int M     = (NTAPS + 1) / 2;
  localparam int K     = (SYMM != 0) ? M : NTAPS;
  localparam int CNT_W = $clog2(K + 1);
  localparam int ACC_W = X_W + COEF_W + $clog2(NTAPS);
  localparam int EW    = ((ACC_W + 1 > Y_W) ? ACC_W + 1 : Y_W) + 1;

  localparam logic signed [EW-1:0] ONE  = 1;
  localparam logic signed [EW-1:0] YMAX = (ONE <<< (Y_W - 1)) - ONE;
  localparam logic signed [EW-1:0] YMIN = -(ONE <<< (Y_W - 1));
  localparam logic signed [EW-1:0] RND  = (SHIFT > 0) ? (ONE <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  typedef enum logic {RUN, LOAD} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [COEF_W-1:0]  s_q    [K];
  logic signed [COEF_W-1:0]  s_next [K];
  logic signed [COEF_W-1:0]  c_q    [NTAPS];
  logic signed [COEF_W-1:0]  c_next [NTAPS];
  logic signed [X_W-1:0]     x_q    [NTAPS];

  logic accept;
  logic accept_d;
  logic exit_load;
  logic word_en;
  logic commit;

  // Input handshake: a sample transfers on a rising edge where in_valid && in_ready.
  // in_ready is combinational from state and coef_load only, never from in_valid.
  assign in_ready  = (state == RUN) && !coef_load;
  assign accept    = in_valid && in_ready;
  assign exit_load = (state == LOAD) && !coef_load;
  assign word_en   = (state == LOAD) && coef_load && coef_valid && (cnt != CNT_W'(K));
  assign commit    = word_en && (cnt == CNT_W'(K - 1));

  // Shadow as it will be after this edge, so the final word commits on its own edge.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      s_next[j] = s_q[j];
      if (word_en && (cnt == CNT_W'(j))) s_next[j] = coef_data;
    end
  end

  for (genvar i = 0; i < NTAPS; i++) begin : g_map
    localparam int SRC = (SYMM != 0 && i >= M) ? NTAPS - 1 - i : i;
    assign c_next[i] = s_next[SRC];
  end

  // Coefficient-load controller: state, word counter, shadow/active sets, done/err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      cnt       <= '0;
      coef_done <= 1'b0;
      coef_err  <= 1'b0;
      for (int j = 0; j < K; j++) s_q[j] <= '0;
      for (int i = 0; i < NTAPS; i++) c_q[i] <= (i == NTAPS / 2) ? COEF_W'(1) : '0;
    end else begin
      coef_done <= 1'b0;
      coef_err  <= 1'b0;
      case (state)
        RUN: begin
          if (coef_load) state <= LOAD;
        end
        LOAD: begin
          if (!coef_load) begin
            state    <= RUN;
            cnt      <= '0;
            coef_err <= (cnt != '0) && (cnt != CNT_W'(K));
          end else if (word_en) begin
            cnt <= cnt + CNT_W'(1);
            for (int j = 0; j < K; j++) s_q[j] <= s_next[j];
            if (commit) begin
              coef_done <= 1'b1;
              for (int i = 0; i < NTAPS; i++) c_q[i] <= c_next[i];
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Delay line; a fresh session always starts the filter from silence.
  always_ff @(posedge clk) begin
    if (reset || exit_load) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= in_data;
      for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  logic signed [ACC_W-1:0]        acc;
  logic signed [X_W+COEF_W-1:0]   prod;
  logic signed [X_W:0]            pre;
  logic signed [X_W+COEF_W:0]     fprod;
  logic signed [EW-1:0]           ext;
  logic signed [EW-1:0]           shr;
  logic signed [Y_W-1:0]          y;
  logic                           sat;

  always_comb begin
    acc   = '0;
    prod  = '0;
    pre   = '0;
    fprod = '0;
    if (SYMM != 0) begin
      // Folded form: mirrored taps share one multiplier after a pre-add.
      for (int j = 0; j < NTAPS / 2; j++) begin
        pre   = {x_q[j][X_W-1], x_q[j]} + {x_q[NTAPS-1-j][X_W-1], x_q[NTAPS-1-j]};
        fprod = pre * c_q[j];
        acc   = acc + ACC_W'(fprod);
      end
      if (NTAPS % 2 == 1) begin
        prod = x_q[NTAPS/2] * c_q[NTAPS/2];
        acc  = acc + ACC_W'(prod);
      end
    end else begin
      for (int i = 0; i < NTAPS; i++) begin
        prod = x_q[i] * c_q[i];
        acc  = acc + ACC_W'(prod);
      end
    end
    ext = EW'(acc);
    shr = (ext + RND) >>> SHIFT;
    sat = 1'b0;
    y   = shr[Y_W-1:0];
    if (shr > YMAX) begin
      y   = YMAX[Y_W-1:0];
      sat = 1'b1;
    end else if (shr < YMIN) begin
      y   = YMIN[Y_W-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      accept_d  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      accept_d  <= accept;
      out_valid <= accept_d;
      if (accept_d) begin
        out_data <= y;
        out_sat  <= sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_param.sv
// Bench for fir_stream_param: a plain and a symmetric/rounding instance share one stimulus
// stream; a cycle model with integer arithmetic predicts every output.
module tb_fir_stream_param;

  localparam int NTAPS  = 5;
  localparam int X_W    = 8;
  localparam int COEF_W = 8;
  localparam int Y_W    = 12;
  localparam int MID    = NTAPS / 2;
  localparam int YMAX   = (1 << (Y_W - 1)) - 1;
  localparam int YMIN   = -(1 << (Y_W - 1));

  int cfg_k     [2] = '{5, 3};
  int cfg_shift [2] = '{0, 1};
  int cfg_symm  [2] = '{0, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [X_W-1:0]    in_data;
  logic              in_valid;
  logic              coef_load;
  logic              coef_valid;
  logic [COEF_W-1:0] coef_data;
  logic              rdy  [2];
  logic              ov   [2];
  logic              osat [2];
  logic              done [2];
  logic              err  [2];
  logic [Y_W-1:0]    od   [2];

  fir_stream_param #(.NTAPS(NTAPS), .X_W(X_W), .COEF_W(COEF_W), .Y_W(Y_W), .SHIFT(0), .SYMM(0)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .coef_load(coef_load), .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_done(done[0]), .coef_err(err[0]), .out_data(od[0]), .out_valid(ov[0]), .out_sat(osat[0]));

  fir_stream_param #(.NTAPS(NTAPS), .X_W(X_W), .COEF_W(COEF_W), .Y_W(Y_W), .SHIFT(1), .SYMM(1)) dut_symm (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .coef_load(coef_load), .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_done(done[1]), .coef_err(err[1]), .out_data(od[1]), .out_valid(ov[1]), .out_sat(osat[1]));

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int             m_coef   [2][NTAPS];
  int             m_hist   [2][NTAPS];
  int             m_shadow [2][NTAPS];
  int             m_cnt    [2];
  bit             m_load   [2];
  bit             m_acc_prev [2];
  logic [Y_W-1:0] m_last   [2];
  logic [Y_W:0]   exp_q0[$];
  logic [Y_W:0]   exp_q1[$];
  int             obs0[$];
  int             obs1[$];
  bit             sat0[$];
  bit             sat1[$];
  int             done_cnt [2] = '{0, 0};
  int             err_cnt  [2] = '{0, 0};
  int             load_buf [8];
  int             samp_buf [16];

  function automatic void model_reset(input int g);
    for (int i = 0; i < NTAPS; i++) begin
      m_coef[g][i]   = (i == MID) ? 1 : 0;
      m_hist[g][i]   = 0;
      m_shadow[g][i] = 0;
    end
    m_cnt[g] = 0;
    m_load[g] = 1'b0;
    m_acc_prev[g] = 1'b0;
    m_last[g] = '0;
    if (g == 0) exp_q0.delete(); else exp_q1.delete();
  endfunction

  function automatic logic [Y_W:0] model_y(input int g);
    int s;
    s = 0;
    for (int i = 0; i < NTAPS; i++) s += m_coef[g][i] * m_hist[g][i];
    if (cfg_shift[g] > 0) s = (s + (1 << (cfg_shift[g] - 1))) >>> cfg_shift[g];
    if (s > YMAX) return {1'b1, Y_W'(YMAX)};
    if (s < YMIN) return {1'b1, Y_W'(YMIN)};
    return {1'b0, Y_W'(s)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin : scoreboard
    bit iv, cl, cv, rst, acc, ev, e_done, e_err;
    int din, cd;
    logic [Y_W:0] e;
    iv = in_valid; cl = coef_load; cv = coef_valid; rst = reset;
    din = int'($signed(in_data));
    cd  = int'($signed(coef_data));
    #1;
    for (int g = 0; g < 2; g++) begin
      e_done = 1'b0; e_err = 1'b0; ev = 1'b0; e = '0;
      if (rst) begin
        model_reset(g);
      end else begin
        ev  = m_acc_prev[g];
        acc = iv && !m_load[g] && !cl;
        if (acc) begin
          for (int i = NTAPS - 1; i > 0; i--) m_hist[g][i] = m_hist[g][i-1];
          m_hist[g][0] = din;
          if (g == 0) exp_q0.push_back(model_y(0)); else exp_q1.push_back(model_y(1));
        end
        if (m_load[g]) begin
          if (!cl) begin
            e_err = (m_cnt[g] > 0) && (m_cnt[g] < cfg_k[g]);
            m_cnt[g] = 0;
            m_load[g] = 1'b0;
            for (int i = 0; i < NTAPS; i++) m_hist[g][i] = 0;
          end else if (cv && m_cnt[g] < cfg_k[g]) begin
            m_shadow[g][m_cnt[g]] = cd;
            m_cnt[g]++;
            if (m_cnt[g] == cfg_k[g]) begin
              for (int i = 0; i < NTAPS; i++)
                m_coef[g][i] = (cfg_symm[g] != 0 && i >= cfg_k[g]) ? m_shadow[g][NTAPS-1-i] : m_shadow[g][i];
              e_done = 1'b1;
            end
          end
        end else if (cl) begin
          m_load[g] = 1'b1;
        end
        m_acc_prev[g] = acc;
        if (ev) begin
          if (g == 0) begin
            if (exp_q0.size() > 0) e = exp_q0.pop_front();
            obs0.push_back(int'($signed(od[0])));
            sat0.push_back(osat[0]);
          end else begin
            if (exp_q1.size() > 0) e = exp_q1.pop_front();
            obs1.push_back(int'($signed(od[1])));
            sat1.push_back(osat[1]);
          end
          m_last[g] = e[Y_W-1:0];
        end
      end
      checks++;
      if (ov[g] !== ev) begin
        failures++;
        $display("FAIL out_valid dut=%0d t=%0t got=%b exp=%b", g, $time, ov[g], ev);
      end
      checks++;
      if (od[g] !== m_last[g]) begin
        failures++;
        $display("FAIL out_data dut=%0d t=%0t got=%0d exp=%0d", g, $time, $signed(od[g]), $signed(m_last[g]));
      end
      if (ev || rst) begin
        checks++;
        if (osat[g] !== (ev ? e[Y_W] : 1'b0)) begin
          failures++;
          $display("FAIL out_sat dut=%0d t=%0t got=%b exp=%b", g, $time, osat[g], e[Y_W]);
        end
      end
      checks++;
      if (done[g] !== e_done) begin
        failures++;
        $display("FAIL coef_done dut=%0d t=%0t got=%b exp=%b", g, $time, done[g], e_done);
      end
      checks++;
      if (err[g] !== e_err) begin
        failures++;
        $display("FAIL coef_err dut=%0d t=%0t got=%b exp=%b", g, $time, err[g], e_err);
      end
      if (done[g] === 1'b1) done_cnt[g]++;
      if (err[g] === 1'b1) err_cnt[g]++;
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (rdy[g] !== (!m_load[g] && !coef_load)) begin
          failures++;
          $display("FAIL in_ready dut=%0d t=%0t got=%b exp=%b", g, $time, rdy[g], !m_load[g] && !coef_load);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_samples(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = X_W'(samp_buf[i]);
      wait_cycle();
    end
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) wait_cycle();
  endtask

  task automatic drive_load(input int n, input bit drop);
    coef_load  = 1'b1;
    coef_valid = 1'b0;
    in_valid   = 1'b0;
    wait_cycle();
    for (int i = 0; i < n; i++) begin
      coef_valid = 1'b1;
      coef_data  = COEF_W'(load_buf[i]);
      wait_cycle();
    end
    coef_valid = 1'b0;
    if (drop) begin
      coef_load = 1'b0;
      repeat (2) wait_cycle();
    end
  endtask

  task automatic clear_obs();
    obs0.delete(); obs1.delete(); sat0.delete(); sat1.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0; coef_load = 1'b0; coef_valid = 1'b0; in_data = '0; coef_data = '0;
    repeat (3) wait_cycle();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (ov[g] !== 1'b0 || od[g] !== '0 || osat[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset_out dut=%0d got=%b/%0d/%b exp=0/0/0", g, ov[g], od[g], osat[g]);
      end
      checks++;
      if (done[g] !== 1'b0 || err[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset_coef dut=%0d got=%b/%b exp=0/0", g, done[g], err[g]);
      end
    end
    reset = 1'b0;
    wait_cycle();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdy[g] !== 1'b1) begin
        failures++;
        $display("FAIL reset_ready dut=%0d got=%b exp=1", g, rdy[g]);
      end
    end
  endtask

  task automatic test_impulse();
    int e0 [5] = '{0, 0, 10, 0, 0};
    int e1 [5] = '{0, 0, 5, 0, 0};
    clear_obs();
    samp_buf[0] = 10;
    for (int i = 1; i < 5; i++) samp_buf[i] = 0;
    drive_samples(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] != e0[i]) begin
        failures++;
        $display("FAIL impulse_default dut=0 idx=%0d got=%0d exp=%0d", i, (i < obs0.size()) ? obs0[i] : -99999, e0[i]);
      end
      checks++;
      if (i >= obs1.size() || obs1[i] != e1[i]) begin
        failures++;
        $display("FAIL impulse_default dut=1 idx=%0d got=%0d exp=%0d", i, (i < obs1.size()) ? obs1[i] : -99999, e1[i]);
      end
    end
  endtask

  task automatic test_abort();
    int d0, d1, r0, r1;
    int e0 [5] = '{0, 0, 10, 0, 0};
    d0 = done_cnt[0]; d1 = done_cnt[1]; r0 = err_cnt[0]; r1 = err_cnt[1];
    for (int i = 0; i < 3; i++) load_buf[i] = 7;
    drive_load(3, 1'b1);
    checks++;
    if (err_cnt[0] - r0 != 1 || done_cnt[0] != d0) begin
      failures++;
      $display("FAIL abort_pulses dut=0 got err=%0d done=%0d exp err=1 done=0", err_cnt[0] - r0, done_cnt[0] - d0);
    end
    checks++;
    if (done_cnt[1] - d1 != 1 || err_cnt[1] != r1) begin
      failures++;
      $display("FAIL abort_pulses dut=1 got done=%0d err=%0d exp done=1 err=0", done_cnt[1] - d1, err_cnt[1] - r1);
    end
    clear_obs();
    samp_buf[0] = 10;
    for (int i = 1; i < 5; i++) samp_buf[i] = 0;
    drive_samples(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] != e0[i]) begin
        failures++;
        $display("FAIL abort_keeps dut=0 idx=%0d got=%0d exp=%0d", i, (i < obs0.size()) ? obs0[i] : -99999, e0[i]);
      end
      checks++;
      if (i >= obs1.size() || obs1[i] != 35) begin
        failures++;
        $display("FAIL abort_symm dut=1 idx=%0d got=%0d exp=35", i, (i < obs1.size()) ? obs1[i] : -99999);
      end
    end
  endtask

  task automatic test_load_commit();
    int d0, d1;
    int e0 [10] = '{1, 2, 3, 4, 5, 4, 8, 12, 16, 20};
    int e1 [10] = '{1, 1, 2, 1, 1, 2, 4, 6, 4, 2};
    d0 = done_cnt[0]; d1 = done_cnt[1];
    for (int i = 0; i < 5; i++) load_buf[i] = i + 1;
    drive_load(5, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd99;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdy[g] !== 1'b0) begin
        failures++;
        $display("FAIL load_ready dut=%0d got=%b exp=0", g, rdy[g]);
      end
    end
    in_valid  = 1'b0;
    coef_load = 1'b0;
    repeat (2) wait_cycle();
    checks++;
    if (done_cnt[0] - d0 != 1 || done_cnt[1] - d1 != 1) begin
      failures++;
      $display("FAIL commit_done got=%0d/%0d exp=1/1", done_cnt[0] - d0, done_cnt[1] - d1);
    end
    clear_obs();
    for (int i = 0; i < 10; i++) samp_buf[i] = 0;
    samp_buf[0] = 1;
    samp_buf[5] = 4;
    drive_samples(10);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] != e0[i]) begin
        failures++;
        $display("FAIL commit_impulse dut=0 idx=%0d got=%0d exp=%0d", i, (i < obs0.size()) ? obs0[i] : -99999, e0[i]);
      end
      checks++;
      if (i >= obs1.size() || obs1[i] != e1[i]) begin
        failures++;
        $display("FAIL symm_round dut=1 idx=%0d got=%0d exp=%0d", i, (i < obs1.size()) ? obs1[i] : -99999, e1[i]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) load_buf[i] = 127;
    drive_load(5, 1'b1);
    clear_obs();
    for (int i = 0; i < 5; i++) samp_buf[i] = 127;
    for (int i = 5; i < 10; i++) samp_buf[i] = -128;
    drive_samples(10);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ((g == 0 ? obs0.size() : obs1.size()) != 10) begin
        failures++;
        $display("FAIL sat_count dut=%0d got=%0d exp=10", g, g == 0 ? obs0.size() : obs1.size());
      end else begin
        checks++;
        if ((g == 0 ? obs0[4] : obs1[4]) != 2047 || (g == 0 ? sat0[4] : sat1[4]) != 1'b1) begin
          failures++;
          $display("FAIL sat_pos dut=%0d got=%0d exp=2047 sat=1", g, g == 0 ? obs0[4] : obs1[4]);
        end
        checks++;
        if ((g == 0 ? obs0[9] : obs1[9]) != -2048 || (g == 0 ? sat0[9] : sat1[9]) != 1'b1) begin
          failures++;
          $display("FAIL sat_neg dut=%0d got=%0d exp=-2048 sat=1", g, g == 0 ? obs0[9] : obs1[9]);
        end
      end
    end
  endtask

  task automatic test_conflict();
    int r0, r1;
    r0 = err_cnt[0]; r1 = err_cnt[1];
    clear_obs();
    in_valid  = 1'b1;
    in_data   = 8'd55;
    coef_load = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdy[g] !== 1'b0) begin
        failures++;
        $display("FAIL conflict_ready dut=%0d got=%b exp=0", g, rdy[g]);
      end
    end
    wait_cycle();
    in_valid  = 1'b0;
    coef_load = 1'b0;
    repeat (3) wait_cycle();
    checks++;
    if (obs0.size() != 0 || obs1.size() != 0 || err_cnt[0] != r0 || err_cnt[1] != r1) begin
      failures++;
      $display("FAIL conflict_accept got outs=%0d/%0d errs=%0d/%0d exp=0", obs0.size(), obs1.size(), err_cnt[0] - r0, err_cnt[1] - r1);
    end
  endtask

  task automatic test_reset_midload();
    int r0, r1;
    int e0 [5] = '{0, 0, 10, 0, 0};
    int e1 [5] = '{0, 0, 5, 0, 0};
    r0 = err_cnt[0]; r1 = err_cnt[1];
    load_buf[0] = 3; load_buf[1] = -4;
    drive_load(2, 1'b0);
    reset = 1'b1;
    coef_load = 1'b0;
    repeat (2) wait_cycle();
    reset = 1'b0;
    wait_cycle();
    checks++;
    if (err_cnt[0] != r0 || err_cnt[1] != r1 || ov[0] !== 1'b0 || ov[1] !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset got errs=%0d/%0d valid=%b/%b exp=0", err_cnt[0] - r0, err_cnt[1] - r1, ov[0], ov[1]);
    end
    clear_obs();
    samp_buf[0] = 10;
    for (int i = 1; i < 5; i++) samp_buf[i] = 0;
    drive_samples(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs0.size() || obs0[i] != e0[i]) begin
        failures++;
        $display("FAIL midload_defaults dut=0 idx=%0d got=%0d exp=%0d", i, (i < obs0.size()) ? obs0[i] : -99999, e0[i]);
      end
      checks++;
      if (i >= obs1.size() || obs1[i] != e1[i]) begin
        failures++;
        $display("FAIL midload_defaults dut=1 idx=%0d got=%0d exp=%0d", i, (i < obs1.size()) ? obs1[i] : -99999, e1[i]);
      end
    end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int c = 0; c < 400; c++) begin
      if (left == 0 && $urandom_range(0, 24) == 0) left = $urandom_range(1, 9);
      if (left > 0) begin
        coef_load  = 1'b1;
        coef_valid = 1'($urandom_range(0, 1));
        coef_data  = COEF_W'($urandom_range(0, 40) - 20);
        left--;
      end else begin
        coef_load  = 1'b0;
        coef_valid = 1'b0;
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = X_W'($urandom);
      wait_cycle();
    end
    coef_load = 1'b0; coef_valid = 1'b0; in_valid = 1'b0;
    repeat (4) wait_cycle();
  endtask

  initial begin
    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; coef_load = 1'b0; coef_valid = 1'b0; coef_data = '0;
    test_reset();
    test_impulse();
    test_abort();
    test_load_commit();
    test_saturation();
    test_conflict();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
